mem_access_unit: RTL and testbench

- Load/store sequencer between the pipeline MEM stage and DMEM; directly upstream of DMEM and the only master driving its ports.
- Accepts one byte/halfword/word load or store per valid/ready handshake and performs word-aligned DMEM accesses.
- Performs read-modify-write for sub-word stores, lane extraction and sign/zero extension for loads, and misalignment detection.
- Little-endian byte lanes; DMEM is byte-addressed with 32-bit words.

---
 rtl/mem_access_unit.sv | 130 +++++++++++++
 tb/tb_mem_access_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a word-wide, byte-addressed DMEM.
// Word-aligned accesses only; sub-word stores use read-modify-write, and loads are lane-extracted and extended.
module mem_access_unit #(
   parameter int READ_LAT = 1,
   parameter int ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_misalign,
   output logic [ADDR_W-1:0] DMEM_address,
   output logic [31:0]       DMEM_data_in,
   output logic              DMEM_mem_write,
   output logic              DMEM_mem_read,
   input  logic [31:0]       DMEM_data_out
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic [1:0]        size_q;
   logic              unsigned_q;
   logic [31:0]       wdata_q;
   logic [31:0]       word_q;
   logic              fault_q;
   logic [2:0]        rd_cnt;

   logic              req_fire;
   logic              fault;
   logic              last_rd;
   logic [ADDR_W-1:0] aligned;
   logic [31:0]       merged;
   logic [31:0]       load_data;
   logic [7:0]        byte_lane;
   logic [15:0]       half_lane;

   // Handshake: a request transfers on a clock edge where req_valid and req_ready are both high;
   // req_ready is high only in IDLE and only while rst_n is released.
   assign req_ready = rst_n && (state == IDLE);
   assign req_fire  = req_valid && req_ready;
   assign fault     = (req_size == 2'b11) ||
                      (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
   assign last_rd   = (rd_cnt == 3'(READ_LAT - 1));
   assign aligned   = {addr_q[ADDR_W-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         addr_q     <= '0;
         write_q    <= 1'b0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         wdata_q    <= '0;
         word_q     <= '0;
         fault_q    <= 1'b0;
         rd_cnt     <= '0;
      end else begin
         state <= state_nx;
         if (req_fire) begin
            addr_q     <= req_addr;
            write_q    <= req_write;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata;
            fault_q    <= fault;
         end
         // rd_cnt returns to zero on the last read cycle so every RD visit starts from 0.
         if (state == RD) begin
            rd_cnt <= last_rd ? '0 : rd_cnt + 3'd1;
            if (last_rd) word_q <= DMEM_data_out;
         end
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (req_fire) begin
            if (fault)                                state_nx = RESP;
            else if (req_write && req_size == 2'b10)  state_nx = WR;
            else                                      state_nx = RD;
         end
         RD:   if (last_rd) state_nx = write_q ? WR : RESP;
         WR:   state_nx = RESP;
         RESP: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      merged = word_q;
      unique case (size_q)
         2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   assign byte_lane = word_q[{addr_q[1:0], 3'b000} +: 8];
   assign half_lane = word_q[{addr_q[1], 4'b0000} +: 16];

   always_comb begin
      load_data = word_q;
      unique case (size_q)
         2'b00:   load_data = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
         2'b01:   load_data = {{16{~unsigned_q & half_lane[15]}}, half_lane};
         default: load_data = word_q;
      endcase
   end

   assign DMEM_mem_read  = (state == RD);
   assign DMEM_mem_write = (state == WR);
   assign DMEM_address   = (state == RD || state == WR) ? aligned : '0;
   assign DMEM_data_in   = (state == WR) ? merged : '0;
   assign resp_valid     = (state == RESP);
   assign resp_misalign  = (state == RESP) && fault_q;
   assign resp_rdata     = (state == RESP && !write_q && !fault_q) ? load_data : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (READ_LAT 1 and 3), each with its own DMEM model,
// checked against a word-array reference memory and arithmetic lane/extension rules.
module tb_mem_access_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid     [2];
   logic        req_ready     [2];
   logic        req_write     [2];
   logic [1:0]  req_size      [2];
   logic        req_unsigned  [2];
   logic [31:0] req_addr      [2];
   logic [31:0] req_wdata     [2];
   logic        resp_valid    [2];
   logic [31:0] resp_rdata    [2];
   logic        resp_misalign [2];
   logic [31:0] dmem_address  [2];
   logic [31:0] dmem_data_in  [2];
   logic        mem_write     [2];
   logic        mem_read      [2];
   logic [31:0] dmem_data_out [2];

   logic [31:0] dmem    [2][64];
   logic [31:0] ref_mem [2][64];
   int          wr_events [2];

   int checks;
   int errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_access_unit #(.READ_LAT(g == 0 ? 1 : 3), .ADDR_W(32)) dut (
         .clk            (clk),
         .rst_n          (rst_n),
         .req_valid      (req_valid[g]),
         .req_ready      (req_ready[g]),
         .req_write      (req_write[g]),
         .req_size       (req_size[g]),
         .req_unsigned   (req_unsigned[g]),
         .req_addr       (req_addr[g]),
         .req_wdata      (req_wdata[g]),
         .resp_valid     (resp_valid[g]),
         .resp_rdata     (resp_rdata[g]),
         .resp_misalign  (resp_misalign[g]),
         .DMEM_address   (dmem_address[g]),
         .DMEM_data_in   (dmem_data_in[g]),
         .DMEM_mem_write (mem_write[g]),
         .DMEM_mem_read  (mem_read[g]),
         .DMEM_data_out  (dmem_data_out[g])
      );
      assign dmem_data_out[g] = dmem[g][dmem_address[g][7:2]];
   end

   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (mem_write[u]) begin
            dmem[u][dmem_address[u][7:2]] <= dmem_data_in[u];
            wr_events[u] <= wr_events[u] + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete transaction on unit u, started and finished on a falling edge.
   task automatic xact(input int u, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [7:0] a, input logic [31:0] wd, input bit keep);
      logic [31:0] old_w, new_w, lane, mask, exp_rd, exp_addr;
      bit fault, got, ready_busy;
      int rl, off, exp_lat, exp_rds, exp_wrs, cyc, rds, wrs;
      rl = (u == 0) ? 1 : 3;
      off = int'(a[1:0]);
      exp_addr = {24'd0, a[7:2], 2'b00};
      fault = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
      old_w = ref_mem[u][a[7:2]];
      new_w = old_w;
      exp_rd = 32'd0;
      if (!fault && wr) begin
         if (sz == 2'd2) new_w = wd;
         else begin
            mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
            new_w = (old_w & ~mask) | ((wd << (8 * off)) & mask);
         end
      end else if (!fault) begin
         if (sz == 2'd2) exp_rd = old_w;
         else if (sz == 2'd1) begin
            lane = (old_w >> (8 * off)) & 32'hFFFF;
            exp_rd = (!uns && lane >= 32'h8000) ? lane - 32'h10000 : lane;
         end else begin
            lane = (old_w >> (8 * off)) & 32'hFF;
            exp_rd = (!uns && lane >= 32'h80) ? lane - 32'h100 : lane;
         end
      end
      exp_lat = fault ? 1 : (wr && sz == 2'd2) ? 2 : wr ? rl + 2 : rl + 1;
      exp_rds = (fault || (wr && sz == 2'd2)) ? 0 : rl;
      exp_wrs = (!fault && wr) ? 1 : 0;

      req_valid[u] = 1'b1;
      req_write[u] = wr;
      req_size[u] = sz;
      req_unsigned[u] = uns;
      req_addr[u] = {24'd0, a};
      req_wdata[u] = wd;
      check("ready_before", 32'(req_ready[u]), 32'd1);
      @(posedge clk);
      if (!fault && wr) ref_mem[u][a[7:2]] = new_w;
      got = 0; ready_busy = 0; rds = 0; wrs = 0; cyc = 0;
      while (!got && cyc < 16) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1 && !keep) req_valid[u] = 1'b0;
         if (req_ready[u]) ready_busy = 1;
         check("strobe_excl", 32'(mem_read[u] && mem_write[u]), 32'd0);
         if (mem_read[u]) begin
            rds++;
            check("rd_addr", dmem_address[u], exp_addr);
         end
         if (mem_write[u]) begin
            wrs++;
            check("wr_addr", dmem_address[u], exp_addr);
            check("wr_data", dmem_data_in[u], new_w);
         end
         if (!mem_read[u] && !mem_write[u]) begin
            check("idle_addr", dmem_address[u], 32'd0);
            check("idle_data", dmem_data_in[u], 32'd0);
         end
         if (resp_valid[u]) got = 1;
      end
      check("resp_seen", 32'(got), 32'd1);
      check("latency", 32'(cyc), 32'(exp_lat));
      check("read_cycles", 32'(rds), 32'(exp_rds));
      check("write_cycles", 32'(wrs), 32'(exp_wrs));
      check("rdata", resp_rdata[u], exp_rd);
      check("misalign", 32'(resp_misalign[u]), 32'(fault));
      check("ready_busy", 32'(ready_busy), 32'd0);
      @(negedge clk);
      check("ready_after", 32'(req_ready[u]), 32'd1);
      check("resp_pulse", 32'(resp_valid[u]), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int ev;
      int n;
      checks = 0;
      errors = 0;
      for (int u = 0; u < 2; u++) begin
         req_valid[u] = 1'b0;
         req_write[u] = 1'b0;
         req_size[u] = 2'd0;
         req_unsigned[u] = 1'b0;
         req_addr[u] = 32'd0;
         req_wdata[u] = 32'd0;
         for (int w = 0; w < 64; w++) ref_mem[u][w] = 32'd0;
      end

      // Reset state.
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         check("rst_ready", 32'(req_ready[u]), 32'd0);
         check("rst_resp_valid", 32'(resp_valid[u]), 32'd0);
         check("rst_rdata", resp_rdata[u], 32'd0);
         check("rst_misalign", 32'(resp_misalign[u]), 32'd0);
         check("rst_mem_write", 32'(mem_write[u]), 32'd0);
         check("rst_mem_read", 32'(mem_read[u]), 32'd0);
         check("rst_addr", dmem_address[u], 32'd0);
         check("rst_data_in", dmem_data_in[u], 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_out_of_reset", 32'(req_ready[0]), 32'd1);

      // Fill both memories through word stores with random contents.
      for (int u = 0; u < 2; u++)
         for (int w = 0; w < 64; w++)
            xact(u, 1'b1, 2'd2, 1'b0, 8'(w * 4), $urandom, 1'b0);

      // Word store / word load round trip.
      xact(0, 1'b1, 2'd2, 1'b0, 8'd20, 32'h48, 1'b0);
      xact(0, 1'b0, 2'd2, 1'b0, 8'd20, 32'd0, 1'b0);

      // Byte store read-modify-write.
      xact(0, 1'b1, 2'd2, 1'b0, 8'd40, 32'h11223344, 1'b0);
      xact(0, 1'b1, 2'd0, 1'b0, 8'd42, 32'hAB, 1'b0);
      xact(0, 1'b0, 2'd2, 1'b0, 8'd40, 32'd0, 1'b0);

      // Signed/unsigned lane extraction.
      xact(0, 1'b1, 2'd2, 1'b0, 8'd40, 32'h80F07F01, 1'b0);
      xact(0, 1'b0, 2'd0, 1'b0, 8'd41, 32'd0, 1'b0);
      xact(0, 1'b0, 2'd1, 1'b0, 8'd42, 32'd0, 1'b0);
      xact(0, 1'b0, 2'd1, 1'b1, 8'd42, 32'd0, 1'b0);
      xact(0, 1'b0, 2'd0, 1'b0, 8'd43, 32'd0, 1'b0);

      // Misaligned and illegal-size requests.
      xact(0, 1'b0, 2'd2, 1'b0, 8'd22, 32'd0, 1'b0);
      xact(0, 1'b1, 2'd1, 1'b0, 8'd21, 32'hBEEF, 1'b0);
      xact(0, 1'b0, 2'd3, 1'b0, 8'd8, 32'd0, 1'b0);
      xact(1, 1'b1, 2'd2, 1'b0, 8'd13, 32'h1234, 1'b0);

      // Reset during the read phase of a byte store aborts it without a write.
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_size[0] = 2'd0;
      req_unsigned[0] = 1'b0;
      req_addr[0] = 32'd42;
      req_wdata[0] = 32'hCD;
      check("abort_ready", 32'(req_ready[0]), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("abort_in_rd", 32'(mem_read[0]), 32'd1);
      ev = wr_events[0];
      rst_n = 1'b0;
      req_valid[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_resp", 32'(resp_valid[0]), 32'd0);
      check("abort_write", 32'(mem_write[0]), 32'd0);
      check("abort_read", 32'(mem_read[0]), 32'd0);
      check("abort_ready_low", 32'(req_ready[0]), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_ready_back", 32'(req_ready[0]), 32'd1);
      check("abort_resp_after", 32'(resp_valid[0]), 32'd0);
      check("abort_no_write", 32'(wr_events[0]), 32'(ev));
      xact(0, 1'b0, 2'd2, 1'b0, 8'd40, 32'd0, 1'b0);

      // READ_LAT=3 instance: back-to-back loads with req_valid held high.
      xact(1, 1'b0, 2'd2, 1'b0, 8'd0, 32'd0, 1'b1);
      xact(1, 1'b0, 2'd0, 1'b0, 8'd5, 32'd0, 1'b1);
      xact(1, 1'b0, 2'd1, 1'b1, 8'd10, 32'd0, 1'b1);
      xact(1, 1'b0, 2'd2, 1'b0, 8'd64, 32'd0, 1'b0);
      xact(1, 1'b1, 2'd0, 1'b0, 8'd7, 32'h5A, 1'b0);
      xact(1, 1'b0, 2'd2, 1'b0, 8'd4, 32'd0, 1'b0);

      // Randomized traffic on both instances.
      for (int u = 0; u < 2; u++) begin
         n = 150;
         for (int i = 0; i < n; i++)
            xact(u, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), $urandom,
                 (i == n - 1) ? 1'b0 : 1'($urandom_range(0, 1)));
      end

      // Final sweep: every word of each DMEM model matches the reference memory.
      for (int u = 0; u < 2; u++)
         for (int w = 0; w < 64; w++)
            xact(u, 1'b0, 2'd2, 1'b0, 8'(w * 4), 32'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
